// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, state type and parity helper for the PS/2 transmitter
package ps2_pkg;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_START      = 1'b0;
    localparam logic PS2_STOP       = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BIT_HI = 2'd1,
        BIT_LO = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// rtl/ps2_tx_fifo.sv - synchronous scan-code FIFO with registered wrap-bit pointers
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array needs no reset; occupancy is defined by the pointers alone
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ps2_kbd_tx.sv
// rtl/ps2_kbd_tx.sv - PS/2 device-side transmitter: buffers scan codes and serialises 11-bit frames
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HALF   = 4,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    localparam int CNT_MAX = (CLK_HALF > GAP_CYCLES) ? CLK_HALF : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int SH_W    = PS2_FRAME_BITS - 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    tx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SH_W-1:0]  shreg, shreg_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt;
    logic             clk_nxt, data_nxt;
    logic [7:0]       frame_cnt_nxt;

    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_dout;

    assign in_ready = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign busy     = (state != IDLE) || !fifo_empty;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: each half period and the inter-frame gap are timed by cnt
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = BIT_HI;
            BIT_HI:  if (cnt == HALF_LAST) state_next = BIT_LO;
            BIT_LO:  if (cnt == HALF_LAST) state_next = (bit_idx == LAST_BIT) ? GAP : BIT_HI;
            GAP:     if (cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath next values; data only ever moves on a rising ps2_clk or at frame start
    always_comb begin
        cnt_nxt       = (state_next != state) ? '0 : cnt + 1'b1;
        shreg_nxt     = shreg;
        bit_idx_nxt   = bit_idx;
        clk_nxt       = ps2_clk;
        data_nxt      = ps2_data;
        frame_cnt_nxt = frame_cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!fifo_empty) begin
                    shreg_nxt   = {PS2_STOP, odd_parity(fifo_dout), fifo_dout};
                    bit_idx_nxt = '0;
                    clk_nxt     = 1'b1;
                    data_nxt    = PS2_START;
                end
            end
            BIT_HI: begin
                if (cnt == HALF_LAST)
                    clk_nxt = 1'b0;
            end
            BIT_LO: begin
                if (cnt == HALF_LAST) begin
                    clk_nxt = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        data_nxt      = 1'b1;
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end else begin
                        data_nxt    = shreg[0];
                        shreg_nxt   = {1'b1, shreg[SH_W-1:1]};
                        bit_idx_nxt = bit_idx + 4'd1;
                    end
                end
            end
            GAP: begin
                clk_nxt  = 1'b1;
                data_nxt = 1'b1;
            end
            default: begin
                clk_nxt  = 1'b1;
                data_nxt = 1'b1;
            end
        endcase
    end

    // Registered line drivers, counters and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            shreg     <= '1;
            bit_idx   <= '0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
            frame_cnt <= '0;
        end else begin
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            bit_idx   <= bit_idx_nxt;
            ps2_clk   <= clk_nxt;
            ps2_data  <= data_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

endmodule
